// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: input synchronizers, per-channel glitch filters,
// Gray-code step/direction decode and a loadable wrapping position counter.
module quad_decoder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_count_i,
  input  logic             clr_err_i,
  output logic             step_o,
  output logic             dir_o,
  output logic [WIDTH-1:0] count_o,
  output logic             count_is_max_min_o,
  output logic             err_o,
  output logic             dbg_state_o
);

  localparam int SETTLE_LEN = SYNC_STAGES + FILTER_LEN;
  localparam int SW         = $clog2(SETTLE_LEN + 1);
  localparam int FW         = $clog2(FILTER_LEN + 1);

  typedef enum logic {SETTLE = 1'b0, TRACK = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          settle_cnt;
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0]             synced;    // {A,B}
  logic [1:0]             filt;      // {A,B}
  logic [1:0]             prev;      // {A,B}
  logic [FW-1:0]          fcnt [2];
  logic [1:0]             pos_cur, pos_prev, delta;
  logic                   valid_up, valid_dn, illegal;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_i};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_i};
    end
  end

  assign synced = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // A new level is accepted on the FILTER_LEN-th consecutive cycle it differs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= synced[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= SETTLE;
      settle_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SETTLE) settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // SETTLE lasts SETTLE_LEN cycles plus the capture edge, so prev holds a settled level.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE:  if (settle_cnt == SW'(SETTLE_LEN)) state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = SETTLE;
    endcase
  end

  // Map {A,B} onto the position in the up sequence 00,10,11,01.
  assign pos_cur  = {filt[0], filt[1] ^ filt[0]};
  assign pos_prev = {prev[0], prev[1] ^ prev[0]};
  assign delta    = pos_cur - pos_prev;
  assign valid_up = (state_q == TRACK) && (delta == 2'd1);
  assign valid_dn = (state_q == TRACK) && (delta == 2'd3);
  assign illegal  = (state_q == TRACK) && (delta == 2'd2);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev    <= '0;
      step_o  <= 1'b0;
      dir_o   <= 1'b1;
      count_o <= '0;
      err_o   <= 1'b0;
    end else begin
      prev   <= filt;
      step_o <= (valid_up || valid_dn) && en_i;
      if ((valid_up || valid_dn) && en_i) dir_o <= valid_up;
      if (load_en_i) begin
        count_o <= load_count_i;
      end else if (valid_up && en_i) begin
        count_o <= count_o + WIDTH'(1);
      end else if (valid_dn && en_i) begin
        count_o <= count_o - WIDTH'(1);
      end
      if (illegal) err_o <= 1'b1;
      else if (clr_err_i) err_o <= 1'b0;
    end
  end

  assign count_is_max_min_o = dir_o ? (&count_o) : ~(|count_o);
  assign dbg_state_o        = (state_q == TRACK);

endmodule
